// File: rtl/mips_regfile_scoreboard_if.sv
// Bus bundle between decode/writeback/debug logic and the MIPS GPR file with pending-load scoreboard.
interface mips_regfile_scoreboard_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0] rd_index;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ-1:0]            rd_busy;
  logic                           wa_enable;
  logic [ADDR_WIDTH-1:0]          wa_index;
  logic [DATA_WIDTH-1:0]          wa_data;
  logic                           wb_enable;
  logic [ADDR_WIDTH-1:0]          wb_index;
  logic [DATA_WIDTH-1:0]          wb_data;
  logic                           busy_set;
  logic [ADDR_WIDTH-1:0]          busy_index;
  logic [DATA_WIDTH-1:0]          v0;
  logic                           dump_start;
  logic                           dump_valid;
  logic                           dump_ready;
  logic [ADDR_WIDTH-1:0]          dump_index;
  logic [DATA_WIDTH-1:0]          dump_data;
  logic                           dump_done;

  modport master (
    output rd_index, wa_enable, wa_index, wa_data, wb_enable, wb_index, wb_data,
           busy_set, busy_index, dump_start, dump_ready,
    input  rd_data, rd_busy, v0, dump_valid, dump_index, dump_data, dump_done
  );

  modport slave (
    input  rd_index, wa_enable, wa_index, wa_data, wb_enable, wb_index, wb_data,
           busy_set, busy_index, dump_start, dump_ready,
    output rd_data, rd_busy, v0, dump_valid, dump_index, dump_data, dump_done
  );
endinterface

// File: rtl/mips_regfile_scoreboard.sv
// MIPS GPR file: multi-port combinational reads with optional write bypass, two write ports,
// pending-load scoreboard and a valid/ready serial dump engine.
module mips_regfile_scoreboard #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned V0_INDEX   = 2
) (
  input logic                    clk,
  input logic                    reset,
  mips_regfile_scoreboard_if.slave bus
);
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] V0_IDX   = AW'(V0_INDEX);

  typedef enum logic [1:0] {ST_IDLE, ST_DUMP, ST_DONE} state_e;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DW-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  state_e           state_q, state_d;
  logic             dump_valid_q, dump_valid_d;
  logic             dump_done_q, dump_done_d;
  logic [AW-1:0]    dump_index_q, dump_index_d;

  // Register 0 is hardwired to zero, so writes there are dropped; port B lands last and wins.
  always_comb begin : reg_next
    regs_d = regs_q;
    if (bus.wa_enable && (bus.wa_index != '0)) regs_d[bus.wa_index] = bus.wa_data;
    if (bus.wb_enable && (bus.wb_index != '0)) regs_d[bus.wb_index] = bus.wb_data;
  end

  // A new load issue outranks the returning load on the same register.
  always_comb begin : busy_next
    busy_d = busy_q;
    if (bus.wb_enable) busy_d[bus.wb_index] = 1'b0;
    if (bus.busy_set)  busy_d[bus.busy_index] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin : dump_next
    state_d      = state_q;
    dump_valid_d = dump_valid_q;
    dump_index_d = dump_index_q;
    dump_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.dump_start) begin
          state_d      = ST_DUMP;
          dump_valid_d = 1'b1;
          dump_index_d = '0;
        end
      end
      ST_DUMP: begin
        if (bus.dump_ready) begin
          if (dump_index_q == LAST_IDX) begin
            state_d      = ST_DONE;
            dump_valid_d = 1'b0;
            dump_done_d  = 1'b1;
          end else begin
            dump_index_d = dump_index_q + AW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d      = ST_IDLE;
        dump_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
      busy_q       <= '0;
      state_q      <= ST_IDLE;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      dump_index_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      state_q      <= state_d;
      dump_valid_q <= dump_valid_d;
      dump_done_q  <= dump_done_d;
      dump_index_q <= dump_index_d;
    end
  end

  for (genvar k = 0; k < int'(NUM_READ); k++) begin : g_rd
    logic [AW-1:0] idx_c;
    logic [DW-1:0] data_c;

    assign idx_c = bus.rd_index[k*AW +: AW];

    if (BYPASS != 0) begin : g_byp
      always_comb begin
        data_c = regs_q[idx_c];
        if (idx_c != '0) begin
          if (bus.wb_enable && (bus.wb_index == idx_c))      data_c = bus.wb_data;
          else if (bus.wa_enable && (bus.wa_index == idx_c)) data_c = bus.wa_data;
        end
      end
    end else begin : g_nobyp
      assign data_c = regs_q[idx_c];
    end

    assign bus.rd_data[k*DW +: DW] = data_c;
    assign bus.rd_busy[k]          = busy_q[idx_c];
  end

  assign bus.v0         = regs_q[V0_IDX];
  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_index = dump_index_q;
  assign bus.dump_data  = regs_q[dump_index_q];
  assign bus.dump_done  = dump_done_q;

endmodule

// File: tb/tb_mips_regfile_scoreboard.sv
// Directed plus randomized checks of the GPR file against an array-based reference model.
module tb_mips_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus ();
  mips_regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4)) bus4 ();

  mips_regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(1), .V0_INDEX(2))
    u_dut (.clk(clk), .reset(reset), .bus(bus));
  mips_regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4), .BYPASS(1), .V0_INDEX(2))
    u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected combinational read: zero register, then B bypass, then A bypass, then stored.
  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_enable && bus.wb_index == idx) return bus.wb_data;
    if (bus.wa_enable && bus.wa_index == idx) return bus.wa_data;
    return m_regs[idx];
  endfunction

  task automatic idle_inputs();
    bus.wa_enable = 0; bus.wa_index = 0; bus.wa_data = 0;
    bus.wb_enable = 0; bus.wb_index = 0; bus.wb_data = 0;
    bus.busy_set = 0;  bus.busy_index = 0;
    bus.dump_start = 0; bus.dump_ready = 0;
  endtask

  task automatic idle_inputs4();
    bus4.wa_enable = 0; bus4.wa_index = 0; bus4.wa_data = 0;
    bus4.wb_enable = 0; bus4.wb_index = 0; bus4.wb_data = 0;
    bus4.busy_set = 0;  bus4.busy_index = 0;
    bus4.dump_start = 0; bus4.dump_ready = 0; bus4.rd_index = '0;
  endtask

  // Advance the reference model by the inputs present at this edge, then cross the edge.
  task automatic step();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_busy[i] = 1'b0; end
    end else begin
      if (bus.wa_enable && bus.wa_index != 0) m_regs[bus.wa_index] = bus.wa_data;
      if (bus.wb_enable && bus.wb_index != 0) m_regs[bus.wb_index] = bus.wb_data;
      if (bus.wb_enable) m_busy[bus.wb_index] = 1'b0;
      if (bus.busy_set && bus.busy_index != 0) m_busy[bus.busy_index] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reads(input string tag);
    logic [4:0] idx;
    for (int k = 0; k < 2; k++) begin
      idx = bus.rd_index[k*5 +: 5];
      check({tag, "_rd"}, bus.rd_data[k*32 +: 32], exp_read(idx));
      check({tag, "_busy"}, {31'd0, bus.rd_busy[k]}, {31'd0, m_busy[idx]});
    end
    check({tag, "_v0"}, bus.v0, m_regs[2]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int beats;
    int cyc;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 32'hx; m_busy[i] = 1'b0; end
    idle_inputs();
    idle_inputs4();
    bus.rd_index = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    bus.rd_index = {5'd5, 5'd2};
    #1;
    check_reads("reset");
    check("reset_valid", {31'd0, bus.dump_valid}, 32'd0);
    check("reset_done", {31'd0, bus.dump_done}, 32'd0);
    check("reset_index", {27'd0, bus.dump_index}, 32'd0);

    // Test 1: write then read back
    bus.wa_enable = 1; bus.wa_index = 5'd5; bus.wa_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    bus.rd_index = {5'd0, 5'd5};
    #1;
    check("t1_rd0", bus.rd_data[31:0], 32'hDEADBEEF);
    check("t1_v0", bus.v0, 32'd0);
    check_reads("t1");

    // Test 2: register 0 ignores writes and busy_set
    bus.wa_enable = 1; bus.wa_index = 5'd0; bus.wa_data = 32'h1234;
    bus.busy_set = 1; bus.busy_index = 5'd0;
    step();
    idle_inputs();
    bus.rd_index = {5'd0, 5'd0};
    #1;
    check("t2_rd0", bus.rd_data[31:0], 32'd0);
    check("t2_rd1", bus.rd_data[63:32], 32'd0);
    check("t2_busy", {30'd0, bus.rd_busy}, 32'd0);

    // Test 3: same-cycle A/B collision, B wins on bypass and in storage
    bus.wa_enable = 1; bus.wa_index = 5'd7; bus.wa_data = 32'hA;
    bus.wb_enable = 1; bus.wb_index = 5'd7; bus.wb_data = 32'hB;
    bus.rd_index = {5'd7, 5'd7};
    #1;
    check("t3_byp0", bus.rd_data[31:0], 32'hB);
    check("t3_byp1", bus.rd_data[63:32], 32'hB);
    step();
    idle_inputs();
    #1;
    check("t3_stored", bus.rd_data[31:0], 32'hB);

    // Test 4: scoreboard set / set-wins-over-clear / clear
    bus.busy_set = 1; bus.busy_index = 5'd9;
    step();
    idle_inputs();
    bus.rd_index = {5'd9, 5'd9};
    #1;
    check("t4_set", {31'd0, bus.rd_busy[0]}, 32'd1);
    bus.wb_enable = 1; bus.wb_index = 5'd9; bus.wb_data = 32'h55;
    bus.busy_set = 1; bus.busy_index = 5'd9;
    step();
    idle_inputs();
    #1;
    check("t4_setwins", {31'd0, bus.rd_busy[1]}, 32'd1);
    check("t4_data", bus.rd_data[31:0], 32'h55);
    bus.wb_enable = 1; bus.wb_index = 5'd9; bus.wb_data = 32'h55;
    step();
    idle_inputs();
    #1;
    check("t4_clear", {31'd0, bus.rd_busy[0]}, 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.wa_enable  = 1'($urandom_range(0, 1));
      bus.wa_index   = 5'($urandom_range(0, 11));
      bus.wa_data    = $urandom;
      bus.wb_enable  = 1'($urandom_range(0, 1));
      bus.wb_index   = 5'($urandom_range(0, 11));
      bus.wb_data    = $urandom;
      bus.busy_set   = 1'($urandom_range(0, 1));
      bus.busy_index = 5'($urandom_range(0, 11));
      bus.rd_index   = {($urandom_range(0, 1) != 0) ? bus.wb_index : 5'($urandom_range(0, 31)),
                        ($urandom_range(0, 1) != 0) ? bus.wa_index : 5'($urandom_range(0, 11))};
      #1;
      check_reads("rand");
      step();
    end
    idle_inputs();

    // Test 5: load i*3, dump with ready toggling, one mid-dump write to a later register
    for (int i = 0; i < 32; i++) begin
      bus.wa_enable = 1; bus.wa_index = 5'(i); bus.wa_data = 32'(i * 3);
      step();
    end
    idle_inputs();
    bus.dump_start = 1;
    step();
    bus.dump_start = 0;
    beats = 0;
    cyc = 0;
    while (beats < 32 && cyc < 200) begin
      bus.dump_ready = (cyc % 2 == 0);
      bus.wa_enable = (cyc == 4); bus.wa_index = 5'd20; bus.wa_data = 32'hCAFE0014;
      #1;
      check("t5_valid", {31'd0, bus.dump_valid}, 32'd1);
      check("t5_index", {27'd0, bus.dump_index}, 32'(beats));
      check("t5_data", bus.dump_data, m_regs[beats]);
      check("t5_nodone", {31'd0, bus.dump_done}, 32'd0);
      step();
      if (bus.dump_ready) beats++;
      cyc++;
    end
    idle_inputs();
    check("t5_beats", 32'(beats), 32'd32);
    #1;
    check("t5_done", {31'd0, bus.dump_done}, 32'd1);
    check("t5_endvalid", {31'd0, bus.dump_valid}, 32'd0);
    step();
    check("t5_donepulse", {31'd0, bus.dump_done}, 32'd0);
    check("t5_idlevalid", {31'd0, bus.dump_valid}, 32'd0);

    // Test 6: reset at beat 10 aborts the dump and overrides a concurrent write
    bus.dump_start = 1;
    step();
    bus.dump_start = 0;
    bus.dump_ready = 1;
    for (int i = 0; i < 10; i++) step();
    check("t6_beat10", {27'd0, bus.dump_index}, 32'd10);
    reset = 1;
    bus.wa_enable = 1; bus.wa_index = 5'd3; bus.wa_data = 32'hFFFF;
    step();
    reset = 0;
    idle_inputs();
    bus.dump_ready = 1;
    for (int i = 0; i < 3; i++) begin
      check("t6_valid", {31'd0, bus.dump_valid}, 32'd0);
      check("t6_nodone", {31'd0, bus.dump_done}, 32'd0);
      step();
    end
    bus.dump_ready = 0;
    for (int i = 0; i < 32; i++) begin
      bus.rd_index = {5'(i), 5'(i)};
      #1;
      check("t6_zero", bus.rd_data[31:0], 32'd0);
      check_reads("t6");
    end

    // Four-port instance repeats test 1 on every port
    bus4.wa_enable = 1; bus4.wa_index = 5'd5; bus4.wa_data = 32'hDEADBEEF;
    step();
    idle_inputs4();
    bus4.rd_index = {4{5'd5}};
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t6_p4_rd%0d", k), bus4.rd_data[k*32 +: 32], 32'hDEADBEEF);
      check($sformatf("t6_p4_busy%0d", k), {31'd0, bus4.rd_busy[k]}, 32'd0);
    end
    check("t6_p4_v0", bus4.v0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
